// File: rtl/mem_access_ctrl.sv
// Purpose : core-side initiator for the memory array; one load/store in flight, 32-bit stores done as read-modify-write.
// Latency : load RL+1, 64-bit store WC+1, 32-bit store RL+WC+1, misaligned 1 (accept -> rsp_valid).
// Backpressure: none queued; req_valid is only honoured while busy=0, otherwise dropped.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/we/size/addr/wdata  request from the core (size 0=32-bit, 1=64-bit)
//   busy                        controller not idle
//   rsp_valid/err/rdata         one-cycle completion pulse, error flag, load data (held)
//   mem_address/CS/WE/OE        memory control pins, all registered
//   mem_data_in / mem_data_out  write data to / read data from the memory word
module mem_access_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_CS,
    output logic              mem_WE,
    output logic              mem_OE,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int HALF_W  = DATA_W / 2;
    localparam int CNT_MAX = (READ_LATENCY > WRITE_CYCLES) ? READ_LATENCY : WRITE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Captured request attributes still needed after the accept cycle.
    typedef struct packed {
        logic              we;
        logic              size;
        logic              addr2;   // selects the upper half for 32-bit accesses
        logic [HALF_W-1:0] wlo;     // 32-bit store data
    } op_t;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    op_t              op;

    logic              accept;
    logic              misaligned;
    logic              rd_last;
    logic              wr_last;
    logic [HALF_W-1:0] rd_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    always_comb begin
        misaligned = req_size ? (req_addr[2:0] != 3'b000) : (req_addr[1:0] != 2'b00);
        accept     = (state == S_IDLE) && req_valid;
        rd_last    = (cnt == RD_LAST);
        wr_last    = (cnt == WR_LAST);
        state_nxt  = state;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_nxt = '0;
                    if (misaligned)
                        state_nxt = S_RESP;
                    else if (req_we && req_size)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;   // loads and the read half of a 32-bit store
                end
            end
            S_RD: begin
                if (rd_last) begin
                    cnt_nxt   = '0;
                    state_nxt = op.we ? S_WR : S_RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WR: begin
                if (wr_last) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Data paths valid on the last RD cycle, when mem_data_out is sampled.
    always_comb begin
        rd_half   = op.addr2 ? mem_data_out[DATA_W-1:HALF_W] : mem_data_out[HALF_W-1:0];
        load_data = op.size ? mem_data_out : {{HALF_W{1'b0}}, rd_half};
        merged    = op.addr2 ? {op.wlo, mem_data_out[HALF_W-1:0]}
                             : {mem_data_out[DATA_W-1:HALF_W], op.wlo};
    end

    // Outputs are registered from the next state so strobes line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op          <= '0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_address <= '0;
            mem_CS      <= 1'b0;
            mem_WE      <= 1'b0;
            mem_OE      <= 1'b0;
            mem_data_in <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt != S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);
            mem_CS    <= (state_nxt == S_RD) || (state_nxt == S_WR);
            mem_OE    <= (state_nxt == S_RD);
            mem_WE    <= (state_nxt == S_WR);

            if (accept) begin
                op.we       <= req_we;
                op.size     <= req_size;
                op.addr2    <= req_addr[2];
                op.wlo      <= req_wdata[HALF_W-1:0];
                mem_address <= {3'b000, req_addr[ADDR_W-1:3]};
                if (req_we && req_size && !misaligned)
                    mem_data_in <= req_wdata;
            end

            // Read-modify-write: the merged word is ready for the first WR cycle.
            if ((state == S_RD) && rd_last && op.we)
                mem_data_in <= merged;

            // Response fields are only updated on entry to RESP and then held.
            if (state_nxt == S_RESP) begin
                rsp_err   <= (state == S_IDLE);
                rsp_rdata <= (state == S_RD) ? load_data : '0;
            end
        end
    end

    a_we_oe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_WE && mem_OE));
    a_strobe_cs:  assert property (@(posedge clk) disable iff (!rst_n) (mem_WE || mem_OE) |-> mem_CS);

endmodule
